// File: rtl/lm_sm_pkg.sv
// Shared definitions for the LM/SM sequencer: FSM state encoding and
// default widths / address step used by the top and its sub-modules.
package lm_sm_pkg;

    localparam int unsigned ADDR_W_DEF    = 16;
    localparam int unsigned MASK_W_DEF    = 8;
    localparam int unsigned IDX_W_DEF     = 3;
    localparam int unsigned ADDR_STEP_DEF = 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_FINISH = 2'd2
    } lm_sm_state_e;

endpackage : lm_sm_pkg

// File: rtl/lm_sm_sequencer_lsb_prio_enc.sv
// Lowest-set-bit priority encoder.
//   mask_i : MASK_W-bit request vector
//   idx_o  : index of the lowest set bit (0 when mask_i is all zero)
//   any_o  : 1 when at least one bit of mask_i is set
module lsb_prio_enc
    import lm_sm_pkg::*;
#(
    parameter int unsigned MASK_W = MASK_W_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF
) (
    input  logic [MASK_W-1:0] mask_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic              any_o
);

    // Scan high to low so the lowest set bit is the last to be written.
    always_comb begin
        idx_o = '0;
        for (int i = int'(MASK_W) - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign any_o = |mask_i;

endmodule : lsb_prio_enc

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple sequencer. Latches a register mask and base
// address on START, then issues one memory transfer per set mask bit (lowest
// index first), advancing the address after each acknowledged transfer.
//   CLK, RST                       : clock, synchronous active-high reset
//   START, IS_STORE, BASE_ADDR,
//   MASK                           : launch request and its operands (IDLE only)
//   MEM_ACK                        : memory completed the current request
//   MEM_REQ, MEM_WE, MEM_ADDR      : data-memory request
//   REG_IDX, RF_WE                 : register index and LM write strobe
//   BUSY, DONE                     : pipeline stall and completion pulse
module lm_sm_sequencer
    import lm_sm_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned MASK_W    = MASK_W_DEF,
    parameter int unsigned IDX_W     = IDX_W_DEF,
    parameter int unsigned ADDR_STEP = ADDR_STEP_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              IS_STORE,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [MASK_W-1:0] MASK,
    input  logic              MEM_ACK,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [IDX_W-1:0]  REG_IDX,
    output logic              RF_WE,
    output logic              BUSY,
    output logic              DONE
);

    lm_sm_state_e      state_q, state_d;
    logic [MASK_W-1:0] mask_q,  mask_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              store_q, store_d;

    logic [IDX_W-1:0]  enc_idx;
    logic              enc_any;

    lsb_prio_enc #(
        .MASK_W (MASK_W),
        .IDX_W  (IDX_W)
    ) u_prio_enc (
        .mask_i (mask_q),
        .idx_o  (enc_idx),
        .any_o  (enc_any)
    );

    // State and operand registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            addr_q  <= '0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            store_q <= store_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        store_d = store_q;
        BUSY    = 1'b0;
        MEM_REQ = 1'b0;
        MEM_WE  = 1'b0;
        RF_WE   = 1'b0;
        DONE    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    mask_d  = MASK;
                    addr_d  = BASE_ADDR;
                    store_d = IS_STORE;
                    state_d = (MASK != '0) ? S_ACCESS : S_FINISH;
                end
            end
            S_ACCESS: begin
                BUSY    = 1'b1;
                MEM_REQ = 1'b1;
                MEM_WE  = store_q;
                if (!enc_any) begin
                    // Unreachable with a legal mask; recover rather than hang.
                    state_d = S_FINISH;
                end else if (MEM_ACK) begin
                    RF_WE   = !store_q;
                    mask_d  = mask_q & ~(MASK_W'(1) << enc_idx);
                    addr_d  = addr_q + ADDR_W'(ADDR_STEP);
                    if (mask_d == '0) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign MEM_ADDR = addr_q;
    assign REG_IDX  = enc_idx;

endmodule : lm_sm_sequencer

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
Multi-cycle controller for the load-multiple / store-multiple (LM/SM) instructions of the 16-bit RISC core.
- Takes a register mask and a base address, then issues one memory transfer per set mask bit, lowest register index first.
- Increments the address after each completed transfer.
- Drives register-file index/write-enable for loads and memory write-enable for stores.
- Sits between decode/execute and the data-memory port; holds the pipeline stalled while active.

Parameters:
ADDR_W, 16, width of base and memory address
MASK_W, 8, register mask width; mask bit i selects register Ri
IDX_W, 3, register index width; must equal clog2(MASK_W)
ADDR_STEP, 1, address increment per completed transfer (modulo 2^ADDR_W)

Ports:
CLK  input  1  single clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
START  input  1  launch request; sampled only in IDLE
IS_STORE  input  1  1 = SM (register to memory), 0 = LM (memory to register); sampled with START
BASE_ADDR  input  ADDR_W  first transfer address; sampled with START
MASK  input  MASK_W  register mask; sampled with START
MEM_ACK  input  1  memory has completed the current request this cycle
MEM_REQ  output  1  memory request valid
MEM_WE  output  1  store request (qualified by MEM_REQ)
MEM_ADDR  output  ADDR_W  current transfer address
REG_IDX  output  IDX_W  register being read (SM) or written (LM)
RF_WE  output  1  register-file write strobe for LM
BUSY  output  1  sequence in progress; used as pipeline stall
DONE  output  1  one-cycle pulse after the final transfer (or after an empty mask)

Behaviour:
- States: IDLE, ACCESS, FINISH. Encoding lives in the shared package.
- RST (synchronous, any state, including mid-sequence):
  - next state IDLE
  - latched mask, address and direction cleared to 0
  - all outputs 0 on the following cycle
  - no RF_WE and no MEM_REQ is issued in the cycle after RST
- IDLE:
  - BUSY=0, MEM_REQ=0, RF_WE=0, DONE=0
  - START=1 latches MASK, BASE_ADDR and IS_STORE
  - if MASK!=0, go to ACCESS; if MASK==0, go to FINISH (no memory access)
- ACCESS:
  - BUSY=1, MEM_REQ=1, MEM_WE=latched IS_STORE, MEM_ADDR=current address
  - REG_IDX = index of the lowest set bit of the remaining mask, via the priority encoder
  - Without MEM_ACK: all outputs are held stable, with no timeout.
  - On MEM_ACK=1:
    - RF_WE=1 in the same cycle if LM, combinational from MEM_ACK in ACCESS; RF_WE is never asserted for SM
    - the remaining-mask bit REG_IDX is cleared at the clock edge
    - the address advances by ADDR_STEP at the clock edge, wrapping modulo 2^ADDR_W (0xFFFF+1 = 0x0000)
    - if the remaining mask becomes 0, go to FINISH; otherwise stay in ACCESS (back-to-back ACKs give one transfer per cycle)
- FINISH: DONE=1 and BUSY=0 for exactly one cycle, then IDLE.
- START is ignored in ACCESS and FINISH. A new launch needs START in IDLE, so the minimum gap between DONE and the next MEM_REQ is 2 cycles.
- Latency: the first MEM_REQ appears 1 cycle after START. With ACK every cycle, DONE appears N+1 cycles after START for N set bits.
- MEM_ACK outside ACCESS is ignored.
- Input changes after the START cycle have no effect on a running sequence.

Decomposition:
- Shared package `lm_sm_pkg`:
  - state enum/localparams (S_IDLE=2'd0, S_ACCESS=2'd1, S_FINISH=2'd2)
  - MASK_W and IDX_W defaults
  - ADDR_STEP default
- Sub-module `lsb_prio_enc`: combinational, MASK_W-bit input, outputs IDX_W index of the lowest set bit plus an ANY flag.

Test Plan:
- Basic LM:
  - Stimulus: START, IS_STORE=0, BASE=0x0040, MASK=8'b1010_0101, ACK every cycle.
  - Response: REG_IDX 0,2,5,7 at MEM_ADDR 0x0040..0x0043; four RF_WE pulses; DONE 5 cycles after START.
- SM with stalls:
  - Stimulus: IS_STORE=1, MASK=8'h81, BASE=0x1000; ACK delayed 3 cycles on the first transfer.
  - Response: MEM_WE=1; REG_IDX 0 and MEM_ADDR 0x1000 held for 4 cycles; then REG_IDX 7 at 0x1001; RF_WE never asserted; DONE follows.
- Empty mask:
  - Stimulus: MASK=8'h00, START.
  - Response: no MEM_REQ; DONE pulses 1 cycle after START; BUSY never asserted.
- Address wrap:
  - Stimulus: BASE=0xFFFF, MASK=8'h03, LM.
  - Response: addresses 0xFFFF then 0x0000; REG_IDX 0 then 1.
- Reset mid-sequence and START while busy:
  - Stimulus 1: MASK=8'hFF; assert RST after 3 ACKs.
  - Response 1: next cycle all outputs 0, state IDLE, no DONE.
  - Stimulus 2: a fresh START with MASK=8'h10.
  - Response 2: runs cleanly with REG_IDX 4 at BASE.
  - Stimulus 3: START pulsed during ACCESS.
  - Response 3: no effect on the running sequence.
